// File: rtl/denklem_sweep_ctrl_pkg.sv
// Shared widths, FSM state type and the reference equation y = {1, x, 1}
// for the sweep controller and its bench.
package denklem_pkg;
  localparam int XW   = 3;
  localparam int YW   = 5;
  localparam int SUMW = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    OUT   = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic logic [YW-1:0] exp_y(input logic [XW-1:0] x);
    return {1'b1, x, 1'b1};
  endfunction
endpackage

// File: rtl/denklem_sweep_ctrl_if.sv
// Result stream of the sweep controller: one (x, y) pair per valid/ready handshake.
interface denklem_sweep_ctrl_if #(
  parameter int XW = 3,
  parameter int YW = 5
);
  logic          out_valid;
  logic          out_ready;
  logic [XW-1:0] out_x;
  logic [YW-1:0] out_y;

  modport master (output out_valid, output out_x, output out_y, input out_ready);
  modport slave  (input out_valid, input out_x, input out_y, output out_ready);
endinterface

// File: rtl/denklem_sweep_ctrl_sweep_counter.sv
// Sweep position counter: current x and elements remaining after it.
// cur_nxt exposes the value cur takes on the next edge.
module sweep_counter #(
  parameter int XW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          step,
  input  logic [XW-1:0] load_cur,
  input  logic [XW-1:0] load_rem,
  output logic [XW-1:0] cur,
  output logic [XW-1:0] cur_nxt,
  output logic          last
);
  logic [XW-1:0] cur_q, cur_d;
  logic [XW-1:0] rem_q, rem_d;

  always_comb begin
    cur_d = cur_q;
    rem_d = rem_q;
    if (load) begin
      cur_d = load_cur;
      rem_d = load_rem;
    end else if (step) begin
      // both wrap modulo 2^XW, so a full sweep passes 7 -> 0
      cur_d = cur_q + 1'b1;
      rem_d = rem_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q <= '0;
      rem_q <= '0;
    end else begin
      cur_q <= cur_d;
      rem_q <= rem_d;
    end
  end

  assign cur     = cur_q;
  assign cur_nxt = cur_d;
  assign last    = (rem_q == '0);
endmodule

// File: rtl/denklem_sweep_ctrl.sv
// Sweeps x over [x_start, x_end] (mod 2^XW) through the external equation unit,
// streams each (x, y) and accumulates sum(y). Optional macro DENKLEM_CHECK_EN adds chk_err.
module denklem_sweep_ctrl
  import denklem_pkg::*;
#(
  parameter int XW   = denklem_pkg::XW,
  parameter int YW   = denklem_pkg::YW,
  parameter int SUMW = denklem_pkg::SUMW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XW-1:0]   x_start,
  input  logic [XW-1:0]   x_end,
  output logic [XW-1:0]   x_out,
  input  logic [YW-1:0]   y_in,
  denklem_sweep_ctrl_if.master strm,
  output logic            busy,
  output logic            done,
`ifdef DENKLEM_CHECK_EN
  output logic            chk_err,
`endif
  output logic [SUMW-1:0] sum
);
  state_e          state_q, state_d;
  logic [XW-1:0]   x_out_q, x_out_d;
  logic [XW-1:0]   out_x_q, out_x_d;
  logic [YW-1:0]   out_y_q, out_y_d;
  logic [SUMW-1:0] sum_q, sum_d;
  logic            load, step;
  logic [XW-1:0]   cur, cur_nxt;
  logic            last;
`ifdef DENKLEM_CHECK_EN
  logic            chk_q, chk_d;
`endif

  sweep_counter #(.XW(XW)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .step     (step),
    .load_cur (x_start),
    .load_rem (x_end - x_start),
    .cur      (cur),
    .cur_nxt  (cur_nxt),
    .last     (last)
  );

  always_comb begin
    state_d = state_q;
    out_x_d = out_x_q;
    out_y_d = out_y_q;
    sum_d   = sum_q;
    load    = 1'b0;
    step    = 1'b0;
`ifdef DENKLEM_CHECK_EN
    chk_d   = chk_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          load    = 1'b1;
          sum_d   = '0;
          state_d = DRIVE;
`ifdef DENKLEM_CHECK_EN
          chk_d   = 1'b0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      DRIVE: begin
        out_x_d = cur;
        out_y_d = y_in;
        sum_d   = sum_q + SUMW'(y_in);
        state_d = OUT;
`ifdef DENKLEM_CHECK_EN
        if (y_in != exp_y(cur)) chk_d = 1'b1;
`endif
      end
      OUT: begin
        if (strm.out_ready) begin
          if (last) begin
            state_d = DONE;
          end else begin
            step    = 1'b1;
            state_d = DRIVE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // x_out is registered so it already equals cur throughout DRIVE
    x_out_d = (load || step) ? cur_nxt : x_out_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_out_q <= '0;
      out_x_q <= '0;
      out_y_q <= '0;
      sum_q   <= '0;
`ifdef DENKLEM_CHECK_EN
      chk_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      x_out_q <= x_out_d;
      out_x_q <= out_x_d;
      out_y_q <= out_y_d;
      sum_q   <= sum_d;
`ifdef DENKLEM_CHECK_EN
      chk_q   <= chk_d;
`endif
    end
  end

  assign x_out          = x_out_q;
  assign strm.out_valid = (state_q == OUT);
  assign strm.out_x     = out_x_q;
  assign strm.out_y     = out_y_q;
  assign busy           = (state_q == DRIVE) || (state_q == OUT);
  assign done           = (state_q == DONE);
  assign sum            = sum_q;
`ifdef DENKLEM_CHECK_EN
  assign chk_err        = chk_q;
`endif
endmodule

// File: tb/tb_denklem_sweep_ctrl.sv
// Scoreboard bench for denklem_sweep_ctrl with a behavioural equation unit.
module tb_denklem_sweep_ctrl;
  import denklem_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [XW-1:0]   x_start, x_end;
  logic [XW-1:0]   x_out;
  logic [YW-1:0]   y_in;
  logic            busy, done;
  logic [SUMW-1:0] sum;
  logic            bad_x4 = 1'b0;
`ifdef DENKLEM_CHECK_EN
  logic            chk_err;
`endif

  denklem_sweep_ctrl_if #(.XW(XW), .YW(YW)) sif ();

  denklem_sweep_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .x_start (x_start),
    .x_end   (x_end),
    .x_out   (x_out),
    .y_in    (y_in),
    .strm    (sif),
    .busy    (busy),
    .done    (done),
`ifdef DENKLEM_CHECK_EN
    .chk_err (chk_err),
`endif
    .sum     (sum)
  );

  always #5 clk = ~clk;

  // equation unit, with an injectable fault at x=4
  always_comb y_in = (bad_x4 && x_out == 3'd4) ? '0 : exp_y(x_out);

  int n_cmp = 0;
  int n_err = 0;
  logic [XW-1:0] qx[$];
  logic [YW-1:0] qy[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // drives one accepted start and queues the expected results; returns after the accepting edge
  task automatic do_start(input logic [XW-1:0] xs, input logic [XW-1:0] xe);
    logic [XW-1:0] n1;
    logic [XW-1:0] x;
    n1 = xe - xs;
    x  = xs;
    for (int i = 0; i <= int'(n1); i++) begin
      qx.push_back(x);
      qy.push_back(5'(2 * int'(x) + 17));
      x = x + 1'b1;
    end
    x_start = xs;
    x_end   = xe;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; x_start = '0; x_end = '0; sif.out_ready = 1'b1;
    tick(); tick();
    n_cmp++; if (sif.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", sif.out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
    n_cmp++; if ({x_out, sif.out_x, sif.out_y, sum} !== '0) begin
      n_err++; $display("FAIL reset_data got x_out=%0d out_x=%0d out_y=%0d sum=%0d exp all 0", x_out, sif.out_x, sif.out_y, sum);
    end
`ifdef DENKLEM_CHECK_EN
    n_cmp++; if (chk_err !== 1'b0) begin n_err++; $display("FAIL reset_chk got=%b exp=0", chk_err); end
`endif
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int cyc, first_v, done_cyc;
    sif.out_ready = 1'b1;
    do_start(3'd0, 3'd2);
    cyc = 1; first_v = -1; done_cyc = -1;
    n_cmp++; if (busy !== 1'b1 || x_out !== 3'd0) begin n_err++; $display("FAIL basic_drive got busy=%b x_out=%0d exp busy=1 x_out=0", busy, x_out); end
    while (done_cyc < 0 && cyc < 100) begin
      tick(); cyc++;
      if (sif.out_valid) begin
        if (first_v < 0) first_v = cyc;
        n_cmp++;
        if (qx.size() == 0) begin n_err++; $display("FAIL basic_extra got x=%0d exp no result", sif.out_x); end
        else begin
          if (sif.out_x !== qx[0] || sif.out_y !== qy[0]) begin
            n_err++; $display("FAIL basic_pair got (%0d,%0d) exp (%0d,%0d)", sif.out_x, sif.out_y, qx[0], qy[0]);
          end
          void'(qx.pop_front()); void'(qy.pop_front());
        end
      end
      if (done) done_cyc = cyc;
    end
    n_cmp++; if (first_v !== 2) begin n_err++; $display("FAIL basic_latency got=%0d exp=2", first_v); end
    n_cmp++; if (done_cyc !== 7) begin n_err++; $display("FAIL basic_done_cyc got=%0d exp=7", done_cyc); end
    n_cmp++; if (sum !== 8'd57 || busy !== 1'b0) begin n_err++; $display("FAIL basic_sum got sum=%0d busy=%b exp sum=57 busy=0", sum, busy); end
    n_cmp++; if (qx.size() != 0) begin n_err++; $display("FAIL basic_missing got left=%0d exp=0", qx.size()); end
    qx.delete(); qy.delete();
    tick();
    n_cmp++; if (done !== 1'b0 || sum !== 8'd57) begin n_err++; $display("FAIL basic_hold got done=%b sum=%0d exp done=0 sum=57", done, sum); end
  endtask

  task automatic test_wrap(input logic [XW-1:0] xs, input logic [XW-1:0] xe,
                           input int exp_sum, input int exp_done);
    int cyc, done_cyc, seen;
    sif.out_ready = 1'b1;
    do_start(xs, xe);
    cyc = 1; done_cyc = -1; seen = 0;
    while (done_cyc < 0 && cyc < 100) begin
      tick(); cyc++;
      if (sif.out_valid && qx.size() != 0) begin
        n_cmp++; seen++;
        if (sif.out_x !== qx[0] || sif.out_y !== qy[0]) begin
          n_err++; $display("FAIL wrap_pair got (%0d,%0d) exp (%0d,%0d)", sif.out_x, sif.out_y, qx[0], qy[0]);
        end
        void'(qx.pop_front()); void'(qy.pop_front());
      end
      if (done) done_cyc = cyc;
    end
    n_cmp++; if (done_cyc != exp_done) begin n_err++; $display("FAIL wrap_done_cyc got=%0d exp=%0d", done_cyc, exp_done); end
    n_cmp++; if (int'(sum) != exp_sum) begin n_err++; $display("FAIL wrap_sum got=%0d exp=%0d", sum, exp_sum); end
    n_cmp++; if (qx.size() != 0) begin n_err++; $display("FAIL wrap_missing got left=%0d seen=%0d exp left=0", qx.size(), seen); end
    qx.delete(); qy.delete();
    tick();
  endtask

  task automatic test_stall();
    int cyc, done_cyc;
    sif.out_ready = 1'b0;
    do_start(3'd5, 3'd5);
    cyc = 1; done_cyc = -1;
    while (!sif.out_valid && cyc < 20) begin tick(); cyc++; end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (sif.out_valid !== 1'b1 || sif.out_x !== 3'd5 || sif.out_y !== 5'd27) begin
        n_err++; $display("FAIL stall_hold got v=%b (%0d,%0d) exp v=1 (5,27)", sif.out_valid, sif.out_x, sif.out_y);
      end
      tick(); cyc++;
    end
    sif.out_ready = 1'b1;
    while (done_cyc < 0 && cyc < 40) begin
      if (done) done_cyc = cyc;
      else begin tick(); cyc++; end
    end
    n_cmp++; if (done_cyc < 0 || sum !== 8'd27) begin n_err++; $display("FAIL stall_done got done_cyc=%0d sum=%0d exp done sum=27", done_cyc, sum); end
    qx.delete(); qy.delete();
    tick();
  endtask

  task automatic test_abort();
    int cyc, outs, dones;
    sif.out_ready = 1'b1;
    do_start(3'd0, 3'd3);
    qx.delete(); qy.delete();
    cyc = 1; outs = 0;
    while (outs < 2 && cyc < 20) begin
      tick(); cyc++;
      if (sif.out_valid) outs++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({sif.out_valid, busy, done} !== 3'b000 || {x_out, sif.out_x, sif.out_y, sum} !== '0) begin
      n_err++; $display("FAIL abort_reset got v=%b busy=%b done=%b x_out=%0d x=%0d y=%0d sum=%0d exp all 0",
                        sif.out_valid, busy, done, x_out, sif.out_x, sif.out_y, sum);
    end
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done || sif.out_valid) dones++;
    end
    n_cmp++; if (dones != 0) begin n_err++; $display("FAIL abort_quiet got activity=%0d exp=0", dones); end
  endtask

  task automatic test_busy_start();
    int cyc, done_cyc;
    sif.out_ready = 1'b1;
    do_start(3'd0, 3'd1);
    cyc = 1; done_cyc = -1;
    x_start = 3'd7; x_end = 3'd7; start = 1'b1;
    while (done_cyc < 0 && cyc < 40) begin
      tick(); cyc++;
      start = 1'b0;
      if (sif.out_valid && qx.size() != 0) begin
        n_cmp++;
        if (sif.out_x !== qx[0] || sif.out_y !== qy[0]) begin
          n_err++; $display("FAIL busy_start_pair got (%0d,%0d) exp (%0d,%0d)", sif.out_x, sif.out_y, qx[0], qy[0]);
        end
        void'(qx.pop_front()); void'(qy.pop_front());
      end
      if (done) done_cyc = cyc;
    end
    n_cmp++; if (sum !== 8'd36 || done_cyc != 5) begin n_err++; $display("FAIL busy_start_sum got sum=%0d done_cyc=%0d exp sum=36 done_cyc=5", sum, done_cyc); end
    qx.delete(); qy.delete();
    tick();
    n_cmp++; if (busy !== 1'b0 || sif.out_valid !== 1'b0) begin n_err++; $display("FAIL busy_start_idle got busy=%b v=%b exp 0 0", busy, sif.out_valid); end
  endtask

`ifdef DENKLEM_CHECK_EN
  task automatic test_check();
    int cyc;
    sif.out_ready = 1'b1;
    bad_x4 = 1'b1;
    do_start(3'd3, 3'd5);
    cyc = 1;
    while (!done && cyc < 40) begin tick(); cyc++; end
    n_cmp++; if (chk_err !== 1'b1 || done !== 1'b1) begin n_err++; $display("FAIL chk_set got chk=%b done=%b exp 1 1", chk_err, done); end
    bad_x4 = 1'b0;
    tick();
    n_cmp++; if (chk_err !== 1'b1) begin n_err++; $display("FAIL chk_sticky got=%b exp=1", chk_err); end
    qx.delete(); qy.delete();
    do_start(3'd0, 3'd0);
    n_cmp++; if (chk_err !== 1'b0) begin n_err++; $display("FAIL chk_clear got=%b exp=0", chk_err); end
    cyc = 1;
    while (!done && cyc < 40) begin tick(); cyc++; end
    n_cmp++; if (chk_err !== 1'b0) begin n_err++; $display("FAIL chk_clean got=%b exp=0", chk_err); end
    qx.delete(); qy.delete();
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_wrap(3'd6, 3'd1, 96, 9);
    test_wrap(3'd3, 3'd2, 192, 17);
    test_stall();
    test_abort();
    test_busy_start();
`ifdef DENKLEM_CHECK_EN
    test_check();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "timeout");
  end
endmodule
